// File: rtl/fifo_wptr_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO: binary/gray write
// pointer, read-pointer synchroniser, and registered full/almost-full/level/overflow.
module fifo_wptr_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              wr_clk,
  input  logic              wr_reset,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gr,
  input  logic [ADDR_W:0]   afull_thresh,
  input  logic              clr_ovf,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   wr_ptr_gr,
  output logic              wr_full,
  output logic              wr_almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              wr_overflow
);

  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rq;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] wnext;
  logic [ADDR_W:0] gnext;
  logic [ADDR_W:0] level_next;
  logic            full_next;
  logic            afull_next;
  logic            ovf_next;

  assign wr_accept = wr_en && !wr_full;
  assign wr_addr   = wr_ptr[ADDR_W-1:0];
  assign rq        = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i <= ADDR_W; i++) begin
      rbin[i] = ^(rq >> i);
    end
  end

  always_comb begin
    wnext      = wr_ptr + {{ADDR_W{1'b0}}, wr_accept};
    gnext      = wnext ^ (wnext >> 1);
    full_next  = (gnext == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
    level_next = wnext - rbin;
    afull_next = (level_next >= afull_thresh);
    ovf_next   = (wr_en && wr_full) || (wr_overflow && !clr_ovf);
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      wr_ptr         <= '0;
      wr_ptr_gr      <= '0;
      wr_full        <= 1'b0;
      wr_almost_full <= 1'b0;
      wr_level       <= '0;
      wr_overflow    <= 1'b0;
    end else begin
      sync_q[0] <= rd_ptr_gr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      wr_ptr         <= wnext;
      wr_ptr_gr      <= gnext;
      wr_full        <= full_next;
      wr_almost_full <= afull_next;
      wr_level       <= level_next;
      wr_overflow    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Randomised and directed bench for fifo_wptr_ctrl (ADDR_W=3, SYNC_STAGES=2)
// against an occupancy-count reference model.
module tb_fifo_wptr_ctrl;

  localparam int unsigned AW    = 3;
  localparam int          DEPTH = 8;
  localparam int          MOD   = 16;

  logic          wr_clk = 1'b0;
  logic          wr_reset;
  logic          wr_en;
  logic [AW:0]   rd_ptr_gr;
  logic [AW:0]   afull_thresh;
  logic          clr_ovf;
  logic          wr_accept;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   wr_ptr_gr;
  logic          wr_full;
  logic          wr_almost_full;
  logic [AW:0]   wr_level;
  logic          wr_overflow;

  fifo_wptr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .wr_clk        (wr_clk),
    .wr_reset      (wr_reset),
    .wr_en         (wr_en),
    .rd_ptr_gr     (rd_ptr_gr),
    .afull_thresh  (afull_thresh),
    .clr_ovf       (clr_ovf),
    .wr_accept     (wr_accept),
    .wr_addr       (wr_addr),
    .wr_ptr        (wr_ptr),
    .wr_ptr_gr     (wr_ptr_gr),
    .wr_full       (wr_full),
    .wr_almost_full(wr_almost_full),
    .wr_level      (wr_level),
    .wr_overflow   (wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int checks   = 0;
  int failures = 0;

  // Model: total writes / read position as plain counts; the read position
  // seen by the write side is the value sampled two edges earlier.
  int   m_wr, m_rd, m_level;
  int   hist0, hist1;
  bit   m_full, m_af, m_ovf;
  logic [AW:0] prev_gr;
  int   wq[$];

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    bit acc;
    int rq;
    bit was_reset;
    rd_ptr_gr = to_gray(m_rd % MOD);
    #0;
    acc = wr_en && !m_full;
    check("accept", int'(wr_accept), int'(acc));
    was_reset = !wr_reset;
    if (!wr_reset) begin
      m_wr = 0; hist0 = 0; hist1 = 0;
      m_full = 0; m_af = 0; m_level = 0; m_ovf = 0;
    end else begin
      rq      = hist1;
      m_ovf   = (wr_en && m_full) || (m_ovf && !clr_ovf);
      m_wr    = m_wr + int'(acc);
      m_level = (((m_wr - rq) % MOD) + MOD) % MOD;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= int'(afull_thresh));
      hist1   = hist0;
      hist0   = m_rd % MOD;
    end
    @(posedge wr_clk);
    #1;
    check("wr_ptr",   int'(wr_ptr),         m_wr % MOD);
    check("wr_addr",  int'(wr_addr),        m_wr % DEPTH);
    check("wr_gray",  int'(wr_ptr_gr),      int'(to_gray(m_wr % MOD)));
    check("wr_full",  int'(wr_full),        int'(m_full));
    check("wr_afull", int'(wr_almost_full), int'(m_af));
    check("wr_level", int'(wr_level),       m_level);
    check("wr_ovf",   int'(wr_overflow),    int'(m_ovf));
    if (!was_reset)
      check("gray_step", int'($countones(wr_ptr_gr ^ prev_gr) <= 1), 1);
    prev_gr = wr_ptr_gr;
  endtask

  task automatic do_reset(input int n);
    wr_reset = 1'b0;
    m_rd = 0;
    for (int i = 0; i < n; i++) step();
    wr_reset = 1'b1;
  endtask

  initial begin
    wr_reset = 1'b0; wr_en = 1'b1; clr_ovf = 1'b0;
    afull_thresh = 4'd6; rd_ptr_gr = '0;
    m_wr = 0; m_rd = 0; m_level = 0; hist0 = 0; hist1 = 0;
    m_full = 0; m_af = 0; m_ovf = 0; prev_gr = '0;
    #1;

    // 1. reset with writes requested, then one write
    do_reset(2);
    check("rst_ptr", int'(wr_ptr), 0);
    step();
    check("first_gray", int'(wr_ptr_gr), 1);
    check("first_level", int'(wr_level), 1);

    // 2. fill from empty; 9th request refused
    wr_en = 1'b0;
    do_reset(2);
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("fill_full", int'(wr_full), 1);
    check("fill_gray", int'(wr_ptr_gr), 12);
    check("fill_level", int'(wr_level), 8);
    check("fill_block", int'(wr_accept), 0);
    step();
    check("fill_hold", int'(wr_ptr), 8);
    check("fill_ovf", int'(wr_overflow), 1);

    // 3. read pointer advances by one; release on the 3rd edge
    wr_en = 1'b0;
    m_rd = 1;
    step();
    check("rel_edge1", int'(wr_full), 1);
    step();
    check("rel_edge2", int'(wr_full), 1);
    step();
    check("rel_edge3_full", int'(wr_full), 0);
    check("rel_edge3_level", int'(wr_level), 7);
    wr_en = 1'b1;
    step();
    check("refill", int'(wr_full), 1);

    // 4. almost-full threshold 6, then threshold 0 out of reset
    wr_en = 1'b0; afull_thresh = 4'd6;
    do_reset(1);
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("af_at6", int'(wr_almost_full), 1);
    wr_en = 1'b0; afull_thresh = 4'd0;
    do_reset(1);
    step();
    check("af_zero", int'(wr_almost_full), 1);
    afull_thresh = 4'd6;

    // 5. wrap with the read pointer trailing by four writes
    do_reset(1);
    wq.delete();
    wr_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      m_rd = (wq.size() >= 4) ? wq[wq.size()-4] : 0;
      step();
      check("wrap_nofull", int'(wr_full), 0);
      wq.push_back(m_wr);
    end
    check("wrap_count", m_wr, 40);

    // 6. overflow clear priority, then reset mid-fill
    wr_en = 1'b0;
    do_reset(1);
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) step();
    clr_ovf = 1'b1;
    step();
    check("ovf_set_wins", int'(wr_overflow), 1);
    wr_en = 1'b0;
    step();
    check("ovf_cleared", int'(wr_overflow), 0);
    clr_ovf = 1'b0;
    do_reset(1);
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("mid_level", int'(wr_level), 5);
    do_reset(1);
    check("mid_rst_level", int'(wr_level), 0);

    // random traffic with a lagging, never-overtaking read pointer
    afull_thresh = 4'($urandom_range(0, 9));
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 7) == 0);
      if (m_rd < m_wr && $urandom_range(0, 2) != 0) m_rd = m_rd + 1;
      if ($urandom_range(0, 199) == 0) begin
        wr_en = 1'b0;
        do_reset(1);
        afull_thresh = 4'($urandom_range(0, 9));
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_ctrl.md
Name: fifo_wptr_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO, the parametrised successor of the current write-pointer block. It accepts writes and advances a binary/gray write pointer, and synchronises the read domain's gray pointer internally with a configurable number of stages. From these it produces registered full, almost-full and fill-level outputs plus a sticky overflow flag. Flags are computed from the post-increment pointer, so wr_full is exact on the cycle after the filling write, with no extra cycle of lag.

Parameters:
ADDR_W, 4, RAM address width; depth DEPTH = 2^ADDR_W; pointers are ADDR_W+1 bits (extra wrap bit).
SYNC_STAGES, 2, flop stages on rd_ptr_gr crossing into wr_clk; legal range 2..4.

Ports:
wr_clk  input  1  write-domain clock.
wr_reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising wr_clk.
wr_en  input  1  write request from UART-RX side.
rd_ptr_gr  input  ADDR_W+1  gray read pointer from read domain (asynchronous to wr_clk).
afull_thresh  input  ADDR_W+1  almost-full level threshold, quasi-static.
clr_ovf  input  1  clears wr_overflow.
wr_accept  output  1  combinational: wr_en && !wr_full; RAM write enable.
wr_addr  output  ADDR_W  wr_ptr[ADDR_W-1:0]; RAM write address.
wr_ptr  output  ADDR_W+1  registered binary write pointer.
wr_ptr_gr  output  ADDR_W+1  registered gray write pointer, sent to read domain.
wr_full  output  1  registered full flag.
wr_almost_full  output  1  registered, level >= afull_thresh.
wr_level  output  ADDR_W+1  registered fill level, 0..DEPTH.
wr_overflow  output  1  sticky: write attempted while full.

Behaviour:
- Reset (wr_reset=0 at a rising edge): wr_ptr, wr_ptr_gr, wr_full, wr_almost_full, wr_level and wr_overflow all go to 0, and every synchroniser stage goes to 0. Reset applied mid-operation aborts the same cycle and discards any write on that edge.
- Synchroniser: rd_ptr_gr passes through SYNC_STAGES flops to give rq. rq is converted gray-to-binary into rbin (MSB copied, each lower bit = the next-higher binary bit XOR the gray bit).
- Next state:
  - wnext = wr_ptr + wr_accept, modulo 2^(ADDR_W+1).
  - gnext = wnext ^ (wnext>>1).
  - All registers update on every rising wr_clk edge when not in reset.
  - wr_ptr <= wnext; wr_ptr_gr <= gnext. The gray output is registered so it is glitch-free across the crossing.
- Full: wr_full <= (gnext == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]}). This is equivalent to wnext and rbin having equal low ADDR_W bits and a differing MSB.
- Level: wr_level <= (wnext - rbin) mod 2^(ADDR_W+1). The range is 0..DEPTH. wr_level == DEPTH exactly when wr_full is 1.
- Almost-full: wr_almost_full <= (wnext - rbin) >= afull_thresh.
  - afull_thresh = 0: almost-full is 1 out of reset.
  - afull_thresh > DEPTH: almost-full never asserts.
- Overflow: set when wr_en && wr_full. Cleared when clr_ovf && !(wr_en && wr_full). Set wins over clear in the same cycle.
- Full boundary: while wr_full=1, wr_accept=0, and the pointer, gray and level hold.
- Read-side release latency: a change on rd_ptr_gr is reflected in wr_full, wr_level and wr_almost_full SYNC_STAGES+1 wr_clk edges later.
  - Flags are pessimistic: a stale rq can only over-report the level, never under-report it.
- Wrap-around: the pointer wraps from 2^(ADDR_W+1)-1 to 0 with a single-bit gray change. The full and level arithmetic are correct across the wrap.
- Simultaneous write and read-pointer update: both take effect together in wnext - rbin. A write on a full cycle is impossible because wr_accept is gated.
- Gray code invariant: wr_ptr_gr changes by at most one bit per cycle.

Test Plan:
(All scenarios use ADDR_W=3, DEPTH=8, SYNC_STAGES=2.)
1. Reset: hold wr_reset=0 for 2 edges with wr_en=1 -> all outputs 0, wr_accept=1 combinationally, but wr_ptr stays 0. Release, then 1 write -> wr_ptr=1, wr_ptr_gr=0001, wr_level=1.
2. Fill: rd_ptr_gr=0, wr_en=1 for 9 cycles -> exactly 8 accepts.
   - After the 8th edge: wr_full=1, wr_ptr=1000, wr_ptr_gr=1100, wr_level=8.
   - 9th cycle: wr_accept=0, pointer holds, wr_overflow=1 from the next edge.
3. Release: from full, drive rd_ptr_gr 0000->0001 -> wr_full=0 and wr_level=7 on the 3rd edge after the change (not earlier). A write that cycle gives wr_full=1 again on the next edge.
4. Almost-full: afull_thresh=6, empty FIFO, write 6 -> wr_almost_full rises on the same edge wr_level becomes 6. Set afull_thresh=0 after reset -> wr_almost_full=1 on the first edge.
5. Wrap: 40 writes with rd_ptr_gr tracking wr_ptr_gr delayed by 4 cycles -> wr_ptr wraps 1111->0000 (gray 1000->0000), and wr_full never asserts. Every wr_ptr_gr step is a single-bit change.
6. Overflow clear, with wr_full=1:
   - clr_ovf=1 and wr_en=1 together -> wr_overflow stays 1.
   - clr_ovf=1 alone -> wr_overflow=0.
   - Reset asserted mid-fill at wr_level=5 -> all outputs 0 on that edge.
